// File: rtl/m2s_pkg.sv
// Shared constants for the MIDI square synth family: base period table,
// MIDI status/controller codes and FSM state encodings.
package m2s_pkg;

   localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
   localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
   localparam logic [3:0] MIDI_CTRL     = 4'hB;

   localparam logic [7:0] CC_SUSTAIN    = 8'd64;
   localparam logic [7:0] CC_ALL_OFF    = 8'd123;

   localparam logic [7:0] AGE_MAX       = 8'hFF;

   // FSM state encodings
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DIV   = 2'd1;
   localparam logic [1:0] ST_ALLOC = 2'd2;

   // Latched message kinds
   localparam logic [1:0] K_ON  = 2'd0;
   localparam logic [1:0] K_OFF = 2'd1;
   localparam logic [1:0] K_ALL = 2'd2;
   localparam logic [1:0] K_PED = 2'd3;

   // Full period in 12 MHz ticks for notes 48..59; unused slots return 0
   function automatic logic [16:0] base_period(input logic [3:0] idx);
      case (idx)
         4'd0:    base_period = 17'd91736;
         4'd1:    base_period = 17'd86587;
         4'd2:    base_period = 17'd81728;
         4'd3:    base_period = 17'd77141;
         4'd4:    base_period = 17'd72811;
         4'd5:    base_period = 17'd68724;
         4'd6:    base_period = 17'd64867;
         4'd7:    base_period = 17'd61227;
         4'd8:    base_period = 17'd57790;
         4'd9:    base_period = 17'd54547;
         4'd10:   base_period = 17'd51485;
         4'd11:   base_period = 17'd48596;
         default: base_period = 17'd0;
      endcase
   endfunction

endpackage

// File: rtl/square_voice.sv
// One square-wave oscillator voice: note/velocity/half-period, tick and phase,
// age for stealing. Optional sustain flag under SYNTH_SUSTAIN_EN.
module square_voice
   import m2s_pkg::*;
#(
   parameter int unsigned PER_W = 25
) (
   input  logic             clk,
   input  logic             resetq,
   input  logic             load,
   input  logic             rel,
   input  logic             clear,
   input  logic             age_inc,
   input  logic [7:0]       note_in,
   input  logic [6:0]       vel_in,
   input  logic [PER_W-1:0] half_in,
`ifdef SYNTH_SUSTAIN_EN
   input  logic             sus_mark,
   input  logic             sus_drop,
   output logic             sustained,
`endif
   output logic             active,
   output logic             phase,
   output logic [7:0]       note,
   output logic [6:0]       vel,
   output logic [7:0]       age
);

   logic [PER_W-1:0] half;
   logic [PER_W-1:0] tick;
   logic             go_idle;

`ifdef SYNTH_SUSTAIN_EN
   assign go_idle = rel | (sus_drop & sustained);

   // Sustain flag: set by a pedal-held note-off, dropped by pedal up or reload
   always_ff @(posedge clk) begin
      if (resetq || clear || load) sustained <= 1'b0;
      else if (sus_drop)           sustained <= 1'b0;
      else if (sus_mark && active) sustained <= 1'b1;
   end
`else
   assign go_idle = rel;
`endif

   // Voice state and oscillator: tick runs 0..half-1, phase toggles on wrap
   always_ff @(posedge clk) begin
      if (resetq) begin
         active <= 1'b0;
         phase  <= 1'b0;
         note   <= 8'd0;
         vel    <= 7'd0;
         half   <= '0;
         tick   <= '0;
         age    <= 8'd0;
      end else if (clear) begin
         active <= 1'b0;
         phase  <= 1'b0;
         tick   <= '0;
         age    <= 8'd0;
      end else if (load) begin
         active <= 1'b1;
         phase  <= 1'b0;
         note   <= note_in;
         vel    <= vel_in;
         half   <= half_in;
         tick   <= '0;
         age    <= 8'd0;
      end else if (go_idle) begin
         active <= 1'b0;
         phase  <= 1'b0;
         tick   <= '0;
      end else if (active) begin
         if (age_inc && age != AGE_MAX) age <= age + 8'd1;
         if (tick == half - PER_W'(1)) begin
            tick  <= '0;
            phase <= ~phase;
         end else begin
            tick  <= tick + PER_W'(1);
         end
      end
   end

endmodule

// File: rtl/poly_square_synth.sv
// Polyphonic MIDI square synth: message decode, note-to-period divider,
// voice allocation/stealing, velocity mixer and sigma-delta buzz output.
// Optional sustain pedal support under SYNTH_SUSTAIN_EN.
module poly_square_synth
   import m2s_pkg::*;
#(
   parameter int unsigned CLK_HZ = 12000000,
   parameter int unsigned VOICES = 4,
   parameter int unsigned PER_W  = 25,
   parameter int unsigned OMNI   = 0
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              msg_valid,
   output logic              msg_ready,
   input  logic [7:0]        status,
   input  logic [7:0]        data1,
   input  logic [7:0]        data2,
   input  logic [3:0]        midi_chan,
   output logic              buzz,
   output logic [VOICES-1:0] voice_active
);

   localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int unsigned SUM_W = 7 + $clog2(VOICES + 1);
   localparam int unsigned ACC_W = SUM_W + 1;
   localparam logic [ACC_W-1:0] ACC_TH = ACC_W'(VOICES * 127);

   logic [1:0] state, state_nxt, kind, kind_d;
   logic [6:0] r;
   logic [2:0] oct;
   logic [7:0] lat_note;
   logic [6:0] lat_vel;
   logic       chan_ok, on_ok, off_ok, all_ok, ped_ok, cmd_ok, accept;

   // Base period table rescaled to the actual clock at elaboration
   logic [PER_W-1:0] base_tab [16];
   for (genvar g = 0; g < 16; g++) begin : g_tab
      localparam logic [63:0] SCALED =
         64'(base_period(4'(g))) * 64'(CLK_HZ) / 64'd12000000;
      assign base_tab[g] = PER_W'(SCALED);
   end

   // Classify the incoming message; anything unrecognised is consumed silently
   always_comb begin
      chan_ok = (OMNI != 0) || (status[3:0] == midi_chan);
      on_ok   = (status[7:4] == MIDI_NOTE_ON) && (data2 != 8'd0) &&
                (data1 >= 8'd24) && (data1 < 8'd120);
      off_ok  = (status[7:4] == MIDI_NOTE_OFF) ||
                ((status[7:4] == MIDI_NOTE_ON) && (data2 == 8'd0));
      all_ok  = (status[7:4] == MIDI_CTRL) && (data1 == CC_ALL_OFF);
      ped_ok  = 1'b0;
`ifdef SYNTH_SUSTAIN_EN
      ped_ok  = (status[7:4] == MIDI_CTRL) && (data1 == CC_SUSTAIN);
`endif
      kind_d  = K_ON;
      if (off_ok)      kind_d = K_OFF;
      else if (all_ok) kind_d = K_ALL;
      else if (ped_ok) kind_d = K_PED;
      cmd_ok  = chan_ok && (on_ok || off_ok || all_ok || ped_ok);
      accept  = (state == ST_IDLE) && msg_valid && msg_ready && cmd_ok;
   end

   // Next-state logic; DIV looks ahead so it leaves on the step that lands r<12
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = (kind_d == K_ON) ? ST_DIV : ST_ALLOC;
         ST_DIV:   if (r < 7'd24) state_nxt = ST_ALLOC;
         ST_ALLOC: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register and ready flag
   always_ff @(posedge clk) begin
      if (resetq) begin
         state     <= ST_IDLE;
         msg_ready <= 1'b1;
      end else begin
         state     <= state_nxt;
         msg_ready <= (state_nxt == ST_IDLE);
      end
   end

   // Message latch and divide-by-12 into semitone and octave
   always_ff @(posedge clk) begin
      if (resetq) begin
         lat_note <= 8'd0;
         lat_vel  <= 7'd0;
         kind     <= K_ON;
         r        <= 7'd0;
         oct      <= 3'd0;
      end else if (accept) begin
         lat_note <= data1;
         lat_vel  <= data2[6:0];
         kind     <= kind_d;
         r        <= 7'(data1 - 8'd24);
         oct      <= 3'd0;
      end else if (state == ST_DIV && r >= 7'd12) begin
         r        <= r - 7'd12;
         oct      <= oct + 3'd1;
      end
   end

`ifdef SYNTH_SUSTAIN_EN
   logic lat_ped, pedal;

   // Pedal state, updated when a CC64 message reaches ALLOC
   always_ff @(posedge clk) begin
      if (resetq) begin
         lat_ped <= 1'b0;
         pedal   <= 1'b0;
      end else begin
         if (accept) lat_ped <= (data2 >= 8'd64);
         if (state == ST_ALLOC && kind == K_PED) pedal <= lat_ped;
      end
   end
`endif

   // Octave-shift the base period; octave 2 uses the table value as is
   logic [PER_W-1:0] base, period, half_new;
   always_comb begin
      base = base_tab[r[3:0]];
      if (oct < 3'd2) period = base << (3'd2 - oct);
      else            period = base >> (oct - 3'd2);
      half_new = period >> 1;
   end

   logic [VOICES-1:0] ph, v_load, v_rel, v_clear, v_inc;
   logic [7:0]        v_note [VOICES];
   logic [6:0]        v_vel  [VOICES];
   logic [7:0]        v_age  [VOICES];
`ifdef SYNTH_SUSTAIN_EN
   logic [VOICES-1:0] v_sus, v_mark;
   logic              v_drop;
`endif

   logic             hit, free;
   logic [IDX_W-1:0] hit_idx, free_idx, old_idx, sel;
   logic [8:0]       key, old_key;

   // Voice allocation: retrigger same note, else lowest idle, else steal oldest
   always_comb begin
      v_load   = '0;
      v_rel    = '0;
      v_clear  = '0;
      v_inc    = '0;
`ifdef SYNTH_SUSTAIN_EN
      v_mark   = '0;
      v_drop   = 1'b0;
`endif
      hit      = 1'b0;
      free     = 1'b0;
      hit_idx  = '0;
      free_idx = '0;
      old_idx  = '0;
      old_key  = '0;
      key      = '0;
      for (int i = 0; i < VOICES; i++) begin
         if (!hit && voice_active[i] && v_note[i] == lat_note) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
         if (!free && !voice_active[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
`ifdef SYNTH_SUSTAIN_EN
         key = {v_sus[i], v_age[i]};
`else
         key = {1'b0, v_age[i]};
`endif
         if (key > old_key) begin
            old_key = key;
            old_idx = IDX_W'(i);
         end
      end
      sel = hit ? hit_idx : (free ? free_idx : old_idx);
      if (state == ST_ALLOC) begin
         case (kind)
            K_ON: begin
               for (int i = 0; i < VOICES; i++) v_load[i] = (IDX_W'(i) == sel);
               v_inc = voice_active & ~v_load;
            end
            K_OFF: begin
               for (int i = 0; i < VOICES; i++) begin
                  if (voice_active[i] && v_note[i] == lat_note) begin
`ifdef SYNTH_SUSTAIN_EN
                     if (pedal) v_mark[i] = 1'b1;
                     else       v_rel[i]  = 1'b1;
`else
                     v_rel[i] = 1'b1;
`endif
                  end
               end
            end
            K_ALL: v_clear = '1;
            default: begin
`ifdef SYNTH_SUSTAIN_EN
               v_drop = !lat_ped;
`endif
            end
         endcase
      end
   end

   for (genvar g = 0; g < VOICES; g++) begin : g_voice
      square_voice #(.PER_W(PER_W)) u_voice (
         .clk       (clk),
         .resetq    (resetq),
         .load      (v_load[g]),
         .rel       (v_rel[g]),
         .clear     (v_clear[g]),
         .age_inc   (v_inc[g]),
         .note_in   (lat_note),
         .vel_in    (lat_vel),
         .half_in   (half_new),
`ifdef SYNTH_SUSTAIN_EN
         .sus_mark  (v_mark[g]),
         .sus_drop  (v_drop),
         .sustained (v_sus[g]),
`endif
         .active    (voice_active[g]),
         .phase     (ph[g]),
         .note      (v_note[g]),
         .vel       (v_vel[g]),
         .age       (v_age[g])
      );
   end

   // Velocity-weighted sum of sounding voices
   logic [SUM_W-1:0] mix_sum;
   always_comb begin
      mix_sum = '0;
      for (int i = 0; i < VOICES; i++) begin
         if (voice_active[i] && ph[i]) mix_sum = mix_sum + SUM_W'(v_vel[i]);
      end
   end

   logic [ACC_W-1:0] acc, acc_sum;
   assign acc_sum = acc + ACC_W'(mix_sum);

   // First-order sigma-delta: overflow past full scale emits a buzz pulse
   always_ff @(posedge clk) begin
      if (resetq) begin
         acc  <= '0;
         buzz <= 1'b0;
      end else if (acc_sum >= ACC_TH) begin
         acc  <= acc_sum - ACC_TH;
         buzz <= 1'b1;
      end else begin
         acc  <= acc_sum;
         buzz <= 1'b0;
      end
   end

endmodule

// File: tb/tb_poly_square_synth.sv
// Directed testbench for poly_square_synth (VOICES=4, 12 MHz table, OMNI=0).
// Sustain checks follow SYNTH_SUSTAIN_EN.
module tb_poly_square_synth;

   localparam int unsigned VOICES = 4;

   logic              clk = 1'b0;
   logic              resetq;
   logic              msg_valid;
   logic              msg_ready;
   logic [7:0]        status, data1, data2;
   logic [3:0]        midi_chan;
   logic              buzz;
   logic [VOICES-1:0] voice_active;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   poly_square_synth #(
      .CLK_HZ(12000000), .VOICES(VOICES), .PER_W(25), .OMNI(0)
   ) dut (
      .clk          (clk),
      .resetq       (resetq),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .status       (status),
      .data1        (data1),
      .data2        (data2),
      .midi_chan    (midi_chan),
      .buzz         (buzz),
      .voice_active (voice_active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      resetq    = 1'b1;
      msg_valid = 1'b0;
      repeat (3) @(negedge clk);
      resetq    = 1'b0;
      @(negedge clk);
   endtask

   // Present one message for a single cycle once the block is ready
   task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
      int n = 0;
      while (!msg_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("ready_timeout", 32'(msg_ready), 1);
      status    = s;
      data1     = d1;
      data2     = d2;
      msg_valid = 1'b1;
      @(negedge clk);
      msg_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!msg_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("busy_timeout", 32'(msg_ready), 1);
   endtask

   task automatic send_wait(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
      send(s, d1, d2);
      wait_ready();
   endtask

   initial begin
      int n, k, cnt;
      status = 8'd0; data1 = 8'd0; data2 = 8'd0; midi_chan = 4'd0;
      msg_valid = 1'b0; resetq = 1'b1;

      // Reset state
      do_reset();
      chk("rst_active", 32'(voice_active), 0);
      chk("rst_buzz",   32'(buzz), 0);
      chk("rst_ready",  32'(msg_ready), 1);

      // A4: r=9, oct=3 -> period 27273, half 13636
      send(8'h90, 8'd69, 8'd127);
      n = 0;
      while (!voice_active[0] && n < 20) begin @(negedge clk); n++; end
      chk("a4_latency", 32'(n), 4);
      chk("a4_active", 32'(voice_active), 32'b0001);
      k = 0;
      while (!buzz && k < 20000) begin @(negedge clk); k++; end
      chk("a4_first_buzz", 32'(k), 13640);
      cnt = 1;
      for (int j = 0; j < 13640; j++) begin
         @(negedge clk);
         if (buzz) cnt++;
      end
      chk("a4_pulses_half", 32'(cnt), 3409);

      // Fill four voices then steal the oldest (voice 0)
      do_reset();
      send_wait(8'h90, 8'd60, 8'd100); chk("fill1", 32'(voice_active), 32'b0001);
      send_wait(8'h90, 8'd64, 8'd100); chk("fill2", 32'(voice_active), 32'b0011);
      send_wait(8'h90, 8'd67, 8'd100); chk("fill3", 32'(voice_active), 32'b0111);
      send_wait(8'h90, 8'd72, 8'd100); chk("fill4", 32'(voice_active), 32'b1111);
      send_wait(8'h90, 8'd76, 8'd100); chk("steal", 32'(voice_active), 32'b1111);
      send_wait(8'h80, 8'd76, 8'd0);   chk("off76_v0", 32'(voice_active), 32'b1110);
      send_wait(8'h80, 8'd64, 8'd0);   chk("off64_v1", 32'(voice_active), 32'b1100);
      send_wait(8'h90, 8'd67, 8'd90);  chk("retrig67", 32'(voice_active), 32'b1100);
      send_wait(8'h80, 8'd67, 8'd0);   chk("off67_v2", 32'(voice_active), 32'b1000);
      send_wait(8'h90, 8'd50, 8'd90);  chk("lowest_idle", 32'(voice_active), 32'b1001);

      // Note-on with velocity 0 acts as note-off; buzz stays quiet
      do_reset();
      send_wait(8'h90, 8'd60, 8'd100); chk("v0_on", 32'(voice_active), 32'b0001);
      send_wait(8'h90, 8'd60, 8'd0);   chk("v0_vel0_off", 32'(voice_active), 32'b0000);
      cnt = 0;
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         if (buzz) cnt++;
      end
      chk("idle_buzz", 32'(cnt), 0);

      // Channel filter and all-notes-off
      do_reset();
      midi_chan = 4'd2;
      send(8'h93, 8'd60, 8'd100);
      chk("wrong_chan_ready", 32'(msg_ready), 1);
      wait_ready();
      chk("wrong_chan", 32'(voice_active), 0);
      send_wait(8'hA2, 8'd60, 8'd100); chk("aftertouch_ign", 32'(voice_active), 0);
      send_wait(8'h92, 8'd60, 8'd100); chk("chan_on", 32'(voice_active), 32'b0001);
      send_wait(8'h92, 8'd64, 8'd90);  chk("chan_on2", 32'(voice_active), 32'b0011);
      send_wait(8'hB2, 8'd7, 8'd0);    chk("cc7_ign", 32'(voice_active), 32'b0011);
      send(8'hB2, 8'd123, 8'd0);
      chk("alloff_pending", 32'(voice_active), 32'b0011);
      @(negedge clk);
      chk("alloff", 32'(voice_active), 0);
      midi_chan = 4'd0;

      // Range limits and top note: 119 -> r=11, oct=7, period 1518, half 759
      do_reset();
      send_wait(8'h90, 8'd23, 8'd100);  chk("note23_ign", 32'(voice_active), 0);
      send_wait(8'h90, 8'd120, 8'd100); chk("note120_ign", 32'(voice_active), 0);
      send(8'h90, 8'd119, 8'd127);
      n = 0;
      while (!msg_ready && n < 40) begin n++; @(negedge clk); end
      chk("n119_busy_le10", 32'(n <= 10), 1);
      chk("n119_active", 32'(voice_active), 32'b0001);
      k = 0;
      while (!buzz && k < 2000) begin @(negedge clk); k++; end
      chk("n119_first_buzz", 32'(k), 763);
      send_wait(8'h80, 8'd50, 8'd0);    chk("off_nomatch", 32'(voice_active), 32'b0001);

      // Reset in the middle of the division aborts the message
      do_reset();
      send(8'h90, 8'd119, 8'd127);
      @(negedge clk);
      resetq = 1'b1;
      @(negedge clk);
      resetq = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(msg_ready), 1);
      repeat (10) @(negedge clk);
      chk("abort_active", 32'(voice_active), 0);

`ifdef SYNTH_SUSTAIN_EN
      // Pedal holds a released note until pedal up
      do_reset();
      send_wait(8'hB0, 8'd64, 8'd127);
      send_wait(8'h90, 8'd60, 8'd100); chk("sus_on", 32'(voice_active), 32'b0001);
      send_wait(8'h80, 8'd60, 8'd0);   chk("sus_held", 32'(voice_active), 32'b0001);
      send_wait(8'hB0, 8'd64, 8'd0);   chk("sus_release", 32'(voice_active), 0);
`else
      // CC64 has no effect without sustain support
      do_reset();
      send(8'hB0, 8'd64, 8'd127);
      chk("cc64_ign_ready", 32'(msg_ready), 1);
      send_wait(8'h90, 8'd60, 8'd100); chk("nosus_on", 32'(voice_active), 32'b0001);
      send_wait(8'h80, 8'd60, 8'd0);   chk("nosus_off", 32'(voice_active), 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
